// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state codes,
// default sizing parameters and byte-lane positions inside a 32-bit word.
package imem_loader_pkg;

  localparam int DEF_MEM_WORDS      = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  // FSM state codes (plain constants so older tools and checkers can use them)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_COUNT = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_CHECK = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERROR = 3'd6;

  // Byte lanes of a little-endian word: the first byte received lands in lane 0
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  // Return word w with byte b placed into the given lane
  function automatic logic [31:0] lane_insert(input logic [31:0] w,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (lane)
      LANE_0:  r[7:0]   = b;
      LANE_1:  r[15:8]  = b;
      LANE_2:  r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_byte_timer.sv
// Inter-byte idle timer: counts cycles while enabled, restarts on every kick,
// and saturates at TIMEOUT_CYCLES where it reports expiry.
module byte_timer
  import imem_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // Idle counter: cleared by a kick, counts while enabled, holds at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (kick) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Serial instruction-memory loader. Stream format: one count byte N, then
// 4*N little-endian data bytes, then one XOR checksum byte over the data.
// Handshake: a byte moves on a rising edge where in_valid && in_ready;
// in_valid may be held while in_ready is low and the byte waits.
// The core is held in reset (cpu_reset) from power-up until the first edge,
// and for the whole load; a failed load keeps it held until a new start.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_WORDS      = DEF_MEM_WORDS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_n;
  logic [7:0]  r_word_idx;
  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic [7:0]  r_csum;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_por;

  logic        w_accept;
  logic        w_start_go;
  logic        w_count_bad;
  logic        w_expired;
  logic        w_more_words;
  logic [31:0] w_word_next;

  assign in_ready     = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign w_accept     = in_valid && in_ready;
  assign w_start_go   = start && ((r_state == ST_IDLE) || (r_state == ST_ERROR));
  assign w_count_bad  = (in_data == 8'd0) || (int'(in_data) > MEM_WORDS);
  assign w_more_words = (r_word_idx + 8'd1) < r_n;
  assign w_word_next  = lane_insert(r_word, r_lane, in_data);

  byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (in_ready),
    .kick   (w_accept || w_start_go),
    .expired(w_expired)
  );

  // Next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_COUNT;
      ST_COUNT: begin
        if (w_accept)       w_next = w_count_bad ? ST_ERROR : ST_DATA;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_DATA: begin
        if (w_accept) begin
          if (r_lane == LANE_3) w_next = ST_WRITE;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end
      end
      ST_WRITE: w_next = w_more_words ? ST_DATA : ST_CHECK;
      ST_CHECK: begin
        if (w_accept)       w_next = (in_data == r_csum) ? ST_DONE : ST_ERROR;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: if (start) w_next = ST_COUNT;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register, word assembly, checksum and write-port registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_word_idx  <= '0;
      r_lane      <= LANE_0;
      r_word      <= '0;
      r_csum      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_por       <= 1'b1;
    end else begin
      r_state <= w_next;
      r_por   <= 1'b0;
      if (w_start_go) begin
        r_n        <= '0;
        r_word_idx <= '0;
        r_lane     <= LANE_0;
        r_word     <= '0;
        r_csum     <= '0;
      end
      if (w_accept && (r_state == ST_COUNT)) begin
        r_n <= in_data;
      end
      if (w_accept && (r_state == ST_DATA)) begin
        r_csum <= r_csum ^ in_data;
        r_word <= w_word_next;
        r_lane <= r_lane + 2'd1;
        if (r_lane == LANE_3) begin
          r_mem_addr  <= {22'd0, r_word_idx, 2'b00};
          r_mem_wdata <= w_word_next;
        end
      end
      if (r_state == ST_WRITE) begin
        r_word_idx <= r_word_idx + 8'd1;
      end
    end
  end

  assign mem_we    = (r_state == ST_WRITE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state == ST_COUNT) || (r_state == ST_DATA) ||
                     (r_state == ST_WRITE) || (r_state == ST_CHECK);
  assign done      = (r_state == ST_DONE);
  assign error     = (r_state == ST_ERROR);
  assign cpu_reset = r_por || busy || error;
  assign dbg_state = r_state;

endmodule
